// File: rtl/acc_writeback_pkg.sv
// rtl/acc_writeback_pkg.sv - shared state encoding and width defaults for the row-sum writeback
package acc_writeback_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } wb_state_e;

endpackage

// File: rtl/acc_writeback_acc_unit.sv
// rtl/acc_writeback_acc_unit.sv - modulo 2^DATA_W accumulator with clear, add and carry-out
module acc_unit
   import acc_writeback_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              add_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sum,
   output logic              carry
);

   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] acc_d;
   logic [DATA_W:0]   full_sum;

   // Running sum plus the incoming term; clear wins over add so a row end restarts at zero
   always_comb begin
      full_sum = {1'b0, acc_q} + {1'b0, din};
      sum      = full_sum[DATA_W-1:0];
      carry    = full_sum[DATA_W];
      acc_d    = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (add_en) begin
         acc_d = full_sum[DATA_W-1:0];
      end
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/acc_writeback.sv
// rtl/acc_writeback.sv - sums each row of the product stream and writes row sums to result BRAM
module acc_writeback
   import acc_writeback_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_rows,
   input  logic              prod_valid,
   input  logic              prod_last,
   input  logic [DATA_W-1:0] prod_in,
   output logic              ena,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic              err_stray
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   wb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] num_q, num_d;
   logic [ADDR_W-1:0] row_idx_q, row_idx_d;
   logic              ena_q, ena_d;
   logic [ADDR_W-1:0] addra_q, addra_d;
   logic [DATA_W-1:0] dina_q, dina_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;

   logic              acc_clr;
   logic              acc_add;
   logic [DATA_W-1:0] acc_sum;
   logic              acc_carry;

   acc_unit #(
      .DATA_W (DATA_W)
   ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .add_en (acc_add),
      .din    (prod_in),
      .sum    (acc_sum),
      .carry  (acc_carry)
   );

   // Next-state, row accounting and write-register load; the output register is the write register,
   // so a row end sampled on one edge drives the BRAM write during the following cycle
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      num_d     = num_q;
      row_idx_d = row_idx_q;
      ena_d     = 1'b0;
      addra_d   = addra_q;
      dina_d    = dina_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      acc_clr   = 1'b0;
      acc_add   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d    = base_addr;
               num_d     = num_rows;
               row_idx_d = '0;
               ovf_d     = 1'b0;
               err_d     = 1'b0;
               acc_clr   = 1'b1;
               state_d   = (num_rows == '0) ? ST_DONE : ST_RUN;
            end else if (prod_valid) begin
               err_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (prod_valid) begin
               if (acc_carry) begin
                  ovf_d = 1'b1;
               end
               if (prod_last) begin
                  acc_clr   = 1'b1;
                  ena_d     = 1'b1;
                  addra_d   = base_q + row_idx_q;
                  dina_d    = acc_sum;
                  row_idx_d = row_idx_q + ONE;
                  if (row_idx_q == num_q - ONE) begin
                     state_d = ST_FLUSH;
                  end
               end else begin
                  acc_add = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            if (prod_valid) begin
               err_d = 1'b1;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (prod_valid) begin
               err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers; reset aborts any job and suppresses a pending write
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         num_q     <= '0;
         row_idx_q <= '0;
         ena_q     <= 1'b0;
         addra_q   <= '0;
         dina_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         num_q     <= num_d;
         row_idx_q <= row_idx_d;
         ena_q     <= ena_d;
         addra_q   <= addra_d;
         dina_q    <= dina_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   assign ena       = ena_q;
   assign wea       = ena_q;
   assign addra     = addra_q;
   assign dina      = dina_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign err_stray = err_q;

endmodule

// File: tb/tb_acc_writeback.sv
// tb/tb_acc_writeback.sv - directed self-checking bench for acc_writeback
module tb_acc_writeback;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [10:0] base_addr = '0;
   logic [10:0] num_rows = '0;
   logic        prod_valid = 1'b0;
   logic        prod_last = 1'b0;
   logic [63:0] prod_in = '0;
   logic        ena, wea, busy, done, ovf, err_stray;
   logic [10:0] addra;
   logic [63:0] dina;

   int checks = 0;
   int errors = 0;

   acc_writeback dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .num_rows   (num_rows),
      .prod_valid (prod_valid),
      .prod_last  (prod_last),
      .prod_in    (prod_in),
      .ena        (ena),
      .wea        (wea),
      .addra      (addra),
      .dina       (dina),
      .busy       (busy),
      .done       (done),
      .ovf        (ovf),
      .err_stray  (err_stray)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [10:0] b, input logic [10:0] n);
      start     = 1'b1;
      base_addr = b;
      num_rows  = n;
      tick();
      start = 1'b0;
   endtask

   task automatic prod(input logic last, input logic [63:0] d);
      prod_valid = 1'b1;
      prod_last  = last;
      prod_in    = d;
      tick();
      prod_valid = 1'b0;
      prod_last  = 1'b0;
   endtask

   task automatic expect_write(input string tag, input logic [10:0] a, input logic [63:0] d);
      check({tag, "_ena"}, ena, 1);
      check({tag, "_wea"}, wea, 1);
      check({tag, "_addr"}, addra, a);
      check({tag, "_data"}, dina, d);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check("rst_ena", ena, 0);
      check("rst_wea", wea, 0);
      check("rst_addr", addra, 0);
      check("rst_data", dina, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err", err_stray, 0);

      // single row 3+4+5
      do_start(11'h010, 11'd1);
      check("t1_busy", busy, 1);
      prod(1'b0, 64'd3);
      check("t1_noena_a", ena, 0);
      prod(1'b0, 64'd4);
      check("t1_noena_b", ena, 0);
      prod(1'b1, 64'd5);
      expect_write("t1", 11'h010, 64'd12);
      check("t1_done_early", done, 0);
      tick();
      check("t1_done", done, 1);
      check("t1_ena_off", ena, 0);
      check("t1_addr_hold", addra, 11'h010);
      check("t1_data_hold", dina, 64'd12);
      tick();
      check("t1_done_off", done, 0);
      check("t1_busy_off", busy, 0);

      // three rows back to back, with a start pulse mid-job that must be ignored
      do_start(11'h020, 11'd3);
      prod(1'b0, 64'd1);
      start = 1'b1;
      base_addr = 11'h100;
      num_rows = 11'd1;
      prod(1'b1, 64'd2);
      start = 1'b0;
      expect_write("t2r0", 11'h020, 64'd3);
      prod(1'b1, 64'd7);
      expect_write("t2r1", 11'h021, 64'd7);
      prod(1'b0, 64'd10);
      check("t2_gap_a", ena, 0);
      prod(1'b0, 64'd20);
      check("t2_gap_b", ena, 0);
      prod(1'b1, 64'd30);
      expect_write("t2r2", 11'h022, 64'd60);
      tick();
      check("t2_done", done, 1);
      tick();
      check("t2_idle", busy, 0);

      // address wrap
      do_start(11'h7FF, 11'd2);
      prod(1'b1, 64'd2);
      expect_write("t3r0", 11'h7FF, 64'd2);
      prod(1'b1, 64'd9);
      expect_write("t3r1", 11'h000, 64'd9);
      tick();
      check("t3_done", done, 1);
      tick();

      // carry-out
      do_start(11'h005, 11'd1);
      check("t4_ovf_clr", ovf, 0);
      prod(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t4_ovf_pre", ovf, 0);
      prod(1'b1, 64'd2);
      expect_write("t4", 11'h005, 64'd1);
      check("t4_ovf", ovf, 1);
      tick();
      tick();
      check("t4_ovf_sticky", ovf, 1);

      // zero rows
      do_start(11'h030, 11'd0);
      check("t5_ovf_clr", ovf, 0);
      check("t5_done", done, 1);
      check("t5_busy", busy, 1);
      check("t5_noena", ena, 0);
      tick();
      check("t5_done_off", done, 0);
      check("t5_busy_off", busy, 0);

      // stray product in IDLE
      prod(1'b1, 64'd99);
      check("t6_err", err_stray, 1);
      check("t6_noena", ena, 0);
      tick();
      check("t6_err_sticky", err_stray, 1);

      // reset mid-row, then a clean job
      do_start(11'h040, 11'd1);
      prod(1'b0, 64'd5);
      prod(1'b0, 64'd6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t7_ena", ena, 0);
      check("t7_wea", wea, 0);
      check("t7_busy", busy, 0);
      check("t7_err", err_stray, 0);
      do_start(11'h040, 11'd1);
      prod(1'b1, 64'd100);
      expect_write("t7", 11'h040, 64'd100);
      tick();
      check("t7_done", done, 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
